// File: rtl/fft_pkg.sv
// Shared constants and FSM state type for the 16-point radix-2 FFT stage sequencer.
package fft_pkg;

    localparam int unsigned N_POINTS   = 16;
    localparam int unsigned LOG2N      = 4;
    localparam int unsigned N_BFLY     = N_POINTS / 2;
    localparam int unsigned MAX_STAGES = LOG2N;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } fsm_state_e;

endpackage

// File: rtl/fft_bfly_addr_gen.sv
// Combinational butterfly operand address and twiddle index generator.
module fft_bfly_addr_gen
    import fft_pkg::*;
(
    input  logic [1:0]       i_stage,
    input  logic [2:0]       i_k,
    output logic [LOG2N-1:0] o_a,
    output logic [LOG2N-1:0] o_b,
    output logic [2:0]       o_tw
);

    logic [3:0] span;
    logic [3:0] pos;
    logic [3:0] grp;

    // span = 2^s, pos = k mod span, grp = k >> s; a and b are span apart.
    always_comb begin
        span = 4'd1 << i_stage;
        pos  = {1'b0, i_k} & (span - 4'd1);
        grp  = {1'b0, i_k} >> i_stage;
        o_a  = ((grp << i_stage) << 1) + pos;
        o_b  = o_a + span;
        o_tw = pos[2:0] << (2'd3 - i_stage);
    end

endmodule

// File: rtl/fft_stage_sequencer.sv
// Sequences the radix-2 stages of a 16-point in-place FFT: issues butterfly reads,
// delays them by the datapath latency into write-backs, and ping-pongs the bank.
module fft_stage_sequencer
    import fft_pkg::*;
#(
    parameter int unsigned BFLY_LAT = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [2:0]       i_n_stages,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_rd_valid,
    output logic [LOG2N-1:0] o_rd_addr_a,
    output logic [LOG2N-1:0] o_rd_addr_b,
    output logic [2:0]       o_tw_idx,
    output logic [1:0]       o_stage,
    output logic             o_wr_en,
    output logic [LOG2N-1:0] o_wr_addr_a,
    output logic [LOG2N-1:0] o_wr_addr_b,
    output logic             o_bank_sel
);

    fsm_state_e       state_q, state_d;
    logic [1:0]       stage_q, stage_d;
    logic [2:0]       k_q, k_d;
    logic [2:0]       n_q, n_d;
    logic             bank_q, bank_d;
    logic             flush;

    logic [2:0]       n_req;
    logic [2:0]       stage_inc;
    logic             rd_valid;
    logic [LOG2N-1:0] gen_a, gen_b;
    logic [2:0]       gen_tw;
    logic [LOG2N-1:0] rd_addr_a, rd_addr_b;

    logic             dl_valid_q [BFLY_LAT];
    logic [LOG2N-1:0] dl_a_q     [BFLY_LAT];
    logic [LOG2N-1:0] dl_b_q     [BFLY_LAT];

    assign n_req     = (i_n_stages > 3'(MAX_STAGES)) ? 3'(MAX_STAGES) : i_n_stages;
    assign stage_inc = {1'b0, stage_q} + 3'd1;

    fft_bfly_addr_gen u_addr_gen (
        .i_stage (stage_q),
        .i_k     (k_q),
        .o_a     (gen_a),
        .o_b     (gen_b),
        .o_tw    (gen_tw)
    );

    // Next-state logic; in DRAIN the k counter is reused to time the latency window.
    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        k_d     = k_q;
        n_d     = n_q;
        bank_d  = bank_q;
        flush   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    n_d     = n_req;
                    stage_d = 2'd0;
                    k_d     = 3'd0;
                    bank_d  = 1'b0;
                    state_d = (n_req != 3'd0) ? StRun : StDone;
                end
            end
            StRun: begin
                if (i_abort) begin
                    flush   = 1'b1;
                    stage_d = 2'd0;
                    k_d     = 3'd0;
                    state_d = StIdle;
                end else if (k_q == 3'(N_BFLY - 1)) begin
                    k_d     = 3'd0;
                    state_d = StDrain;
                end else begin
                    k_d = k_q + 3'd1;
                end
            end
            StDrain: begin
                if (i_abort) begin
                    flush   = 1'b1;
                    stage_d = 2'd0;
                    k_d     = 3'd0;
                    state_d = StIdle;
                end else if (k_q == 3'(BFLY_LAT - 1)) begin
                    k_d    = 3'd0;
                    bank_d = ~bank_q;
                    if (stage_inc < n_q) begin
                        stage_d = stage_inc[1:0];
                        state_d = StRun;
                    end else begin
                        stage_d = 2'd0;
                        state_d = StDone;
                    end
                end else begin
                    k_d = k_q + 3'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM and transform-context registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= StIdle;
            stage_q <= 2'd0;
            k_q     <= 3'd0;
            n_q     <= 3'd0;
            bank_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            k_q     <= k_d;
            n_q     <= n_d;
            bank_q  <= bank_d;
        end
    end

    // Read issue; stage, twiddle and addresses read as zero when no read is issued.
    always_comb begin
        rd_valid  = (state_q == StRun);
        rd_addr_a = rd_valid ? gen_a : '0;
        rd_addr_b = rd_valid ? gen_b : '0;
    end

    // Write-back delay line; an abort empties it so no stale write escapes.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < BFLY_LAT; i++) begin
                dl_valid_q[i] <= 1'b0;
                dl_a_q[i]     <= '0;
                dl_b_q[i]     <= '0;
            end
        end else if (flush) begin
            for (int unsigned i = 0; i < BFLY_LAT; i++) begin
                dl_valid_q[i] <= 1'b0;
                dl_a_q[i]     <= '0;
                dl_b_q[i]     <= '0;
            end
        end else begin
            dl_valid_q[0] <= rd_valid;
            dl_a_q[0]     <= rd_addr_a;
            dl_b_q[0]     <= rd_addr_b;
            for (int unsigned i = 1; i < BFLY_LAT; i++) begin
                dl_valid_q[i] <= dl_valid_q[i-1];
                dl_a_q[i]     <= dl_a_q[i-1];
                dl_b_q[i]     <= dl_b_q[i-1];
            end
        end
    end

    // Output drive.
    always_comb begin
        o_busy      = (state_q == StRun) || (state_q == StDrain);
        o_done      = (state_q == StDone);
        o_rd_valid  = rd_valid;
        o_rd_addr_a = rd_addr_a;
        o_rd_addr_b = rd_addr_b;
        o_tw_idx    = rd_valid ? gen_tw : 3'd0;
        o_stage     = rd_valid ? stage_q : 2'd0;
        o_wr_en     = dl_valid_q[BFLY_LAT-1];
        o_wr_addr_a = dl_a_q[BFLY_LAT-1];
        o_wr_addr_b = dl_b_q[BFLY_LAT-1];
        o_bank_sel  = bank_q;
    end

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed self-checking bench for fft_stage_sequencer with BFLY_LAT=3.
module tb_fft_stage_sequencer;

    localparam int L = 3;
    localparam int P = 8 + L;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_start;
    logic       i_abort;
    logic [2:0] i_n_stages;
    logic       o_busy, o_done, o_rd_valid, o_wr_en, o_bank_sel;
    logic [3:0] o_rd_addr_a, o_rd_addr_b, o_wr_addr_a, o_wr_addr_b;
    logic [2:0] o_tw_idx;
    logic [1:0] o_stage;

    int checks = 0;
    int errors = 0;

    fft_stage_sequencer #(.BFLY_LAT(L)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_start     (i_start),
        .i_abort     (i_abort),
        .i_n_stages  (i_n_stages),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_rd_valid  (o_rd_valid),
        .o_rd_addr_a (o_rd_addr_a),
        .o_rd_addr_b (o_rd_addr_b),
        .o_tw_idx    (o_tw_idx),
        .o_stage     (o_stage),
        .o_wr_en     (o_wr_en),
        .o_wr_addr_a (o_wr_addr_a),
        .o_wr_addr_b (o_wr_addr_b),
        .o_bank_sel  (o_bank_sel)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference address model written in plain integer arithmetic.
    function automatic int ref_a(input int s, input int k);
        int span = 1 << s;
        return ((k / span) * 2 * span + (k % span)) % 16;
    endfunction

    function automatic int ref_b(input int s, input int k);
        return (ref_a(s, k) + (1 << s)) % 16;
    endfunction

    function automatic int ref_tw(input int s, input int k);
        int span = 1 << s;
        return ((k % span) * (8 / span)) % 8;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_done"}, o_done, 0);
        chk({tag, "_rdv"}, o_rd_valid, 0);
        chk({tag, "_rda"}, o_rd_addr_a, 0);
        chk({tag, "_rdb"}, o_rd_addr_b, 0);
        chk({tag, "_tw"}, o_tw_idx, 0);
        chk({tag, "_stage"}, o_stage, 0);
        chk({tag, "_wren"}, o_wr_en, 0);
        chk({tag, "_wra"}, o_wr_addr_a, 0);
        chk({tag, "_wrb"}, o_wr_addr_b, 0);
        chk({tag, "_bank"}, o_bank_sel, 0);
    endtask

    // Starts a transform at the current negedge (cycle 0) and checks every following cycle.
    task automatic run_xfer(input logic [2:0] nin, input int n_eff, input string tag);
        int reads = 0;
        int writes = 0;
        i_n_stages = nin;
        i_start    = 1'b1;
        for (int c = 1; c <= n_eff * P + 3; c++) begin
            int s, k, ws, wk;
            bit erd, ewr;
            @(negedge i_clk);
            i_start = 1'b0;
            s   = (c - 1) / P;
            k   = (c - 1) % P;
            erd = (c >= 1) && (s < n_eff) && (k < 8);
            ws  = (c - 1 - L) / P;
            wk  = (c - 1 - L) % P;
            ewr = (c >= 1 + L) && (ws < n_eff) && (wk < 8);
            if (o_rd_valid === 1'b1) reads++;
            if (o_wr_en === 1'b1) writes++;
            chk($sformatf("%s_busy_c%0d", tag, c), o_busy, (c <= n_eff * P) ? 1 : 0);
            chk($sformatf("%s_done_c%0d", tag, c), o_done, (c == n_eff * P + 1) ? 1 : 0);
            chk($sformatf("%s_rdv_c%0d", tag, c), o_rd_valid, erd ? 1 : 0);
            chk($sformatf("%s_wren_c%0d", tag, c), o_wr_en, ewr ? 1 : 0);
            if (erd) begin
                chk($sformatf("%s_stage_c%0d", tag, c), o_stage, s);
                chk($sformatf("%s_rda_c%0d", tag, c), o_rd_addr_a, ref_a(s, k));
                chk($sformatf("%s_rdb_c%0d", tag, c), o_rd_addr_b, ref_b(s, k));
                chk($sformatf("%s_tw_c%0d", tag, c), o_tw_idx, ref_tw(s, k));
            end else begin
                chk($sformatf("%s_stage0_c%0d", tag, c), o_stage, 0);
                chk($sformatf("%s_tw0_c%0d", tag, c), o_tw_idx, 0);
            end
            if (ewr) begin
                chk($sformatf("%s_wra_c%0d", tag, c), o_wr_addr_a, ref_a(ws, wk));
                chk($sformatf("%s_wrb_c%0d", tag, c), o_wr_addr_b, ref_b(ws, wk));
            end
            // Hand-computed butterfly k=5 points in stages 0, 2 and 3.
            if (n_eff == 4 && c == 6) begin
                chk({tag, "_s0k5_a"}, o_rd_addr_a, 10);
                chk({tag, "_s0k5_b"}, o_rd_addr_b, 11);
                chk({tag, "_s0k5_tw"}, o_tw_idx, 0);
            end
            if (n_eff == 4 && c == 28) begin
                chk({tag, "_s2k5_a"}, o_rd_addr_a, 9);
                chk({tag, "_s2k5_b"}, o_rd_addr_b, 13);
                chk({tag, "_s2k5_tw"}, o_tw_idx, 2);
            end
            if (n_eff == 4 && c == 39) begin
                chk({tag, "_s3k5_a"}, o_rd_addr_a, 5);
                chk({tag, "_s3k5_b"}, o_rd_addr_b, 13);
                chk({tag, "_s3k5_tw"}, o_tw_idx, 5);
            end
        end
        chk({tag, "_reads"}, reads, n_eff * 8);
        chk({tag, "_writes"}, writes, n_eff * 8);
        chk({tag, "_bank_end"}, o_bank_sel, n_eff % 2);
    endtask

    initial begin
        i_rst      = 1'b1;
        i_start    = 1'b0;
        i_abort    = 1'b0;
        i_n_stages = 3'd0;
        #2;
        chk_all_zero("rst0");
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("idle_busy", o_busy, 0);
        chk("idle_done", o_done, 0);

        run_xfer(3'd4, 4, "n4");
        run_xfer(3'd1, 1, "n1");
        run_xfer(3'd6, 4, "n6");
        run_xfer(3'd0, 0, "n0");

        // Abort in DRAIN of stage 0 with start pulses while busy.
        i_n_stages = 3'd4;
        i_start    = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge i_clk);
            if (c <= 10) begin
                chk($sformatf("ab_busy_c%0d", c), o_busy, 1);
                chk($sformatf("ab_rdv_c%0d", c), o_rd_valid, (c <= 8) ? 1 : 0);
                chk($sformatf("ab_wren_c%0d", c), o_wr_en, (c >= 4) ? 1 : 0);
                if (c <= 8) chk($sformatf("ab_rda_c%0d", c), o_rd_addr_a, ref_a(0, c - 1));
            end else begin
                chk($sformatf("ab_busy_c%0d", c), o_busy, 0);
                chk($sformatf("ab_rdv_c%0d", c), o_rd_valid, 0);
                chk($sformatf("ab_wren_c%0d", c), o_wr_en, 0);
            end
            chk($sformatf("ab_done_c%0d", c), o_done, 0);
            i_start = (c == 3 || c == 9) ? 1'b1 : 1'b0;
            i_abort = (c == 10) ? 1'b1 : 1'b0;
        end
        chk("ab_bank", o_bank_sel, 0);

        // Start and abort together in IDLE: start wins; then reset lands mid-transform.
        i_n_stages = 3'd4;
        i_start    = 1'b1;
        i_abort    = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge i_clk);
            i_start = 1'b0;
            i_abort = 1'b0;
            chk($sformatf("sa_busy_c%0d", c), o_busy, 1);
            if (c == 1) chk("sa_rdv_c1", o_rd_valid, 1);
        end
        chk("sa_wren_c20", o_wr_en, 1);
        chk("sa_bank_c20", o_bank_sel, 1);
        i_rst = 1'b1;
        #1;
        chk_all_zero("rst_mid");
        @(negedge i_clk);
        chk_all_zero("rst_hold");
        i_rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge i_clk);
            chk($sformatf("post_rst_done_%0d", c), o_done, 0);
            chk($sformatf("post_rst_busy_%0d", c), o_busy, 0);
        end

        run_xfer(3'd4, 4, "after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_stage_sequencer.md
FFT_STAGE_SEQUENCER -- requirements
Module: fft_stage_sequencer

Interface
REQ-001 SHALL have parameter BFLY_LAT, default 3, butterfly datapath latency in cycles from read issue to write-back (legal range 1..8).
REQ-002 SHALL have port i_clk, input, 1, clock; all state changes on its rising edge.
REQ-003 SHALL have port i_rst, input, 1, reset, asynchronous, active-high.
REQ-004 SHALL have port i_start, input, 1, request to run one transform; sampled only in IDLE.
REQ-005 SHALL have port i_abort, input, 1, synchronous cancel of a running transform.
REQ-006 SHALL have port i_n_stages, input, 3, number of radix-2 stages to run; latched on start.
REQ-007 SHALL have ports o_busy (output, 1, RUN or DRAIN active) and o_done (output, 1, single-cycle completion pulse).
REQ-008 SHALL have ports o_rd_valid (output, 1), o_rd_addr_a and o_rd_addr_b (output, 4 each), o_tw_idx (output, 3), and o_stage (output, 2), giving the butterfly read issue.
REQ-009 SHALL have ports o_wr_en (output, 1) and o_wr_addr_a and o_wr_addr_b (output, 4 each), giving the write-back issue.
REQ-010 SHALL have port o_bank_sel, output, 1, ping-pong bank read by the datapath; the write bank is its inverse.

Function
REQ-011 SHALL implement an FSM with states IDLE, RUN, DRAIN and DONE.
REQ-012 IDLE: when i_start=1, SHALL latch n = min(i_n_stages, 4), set stage=0 and k=0, and clear o_bank_sel to 0; go to RUN if n>0, else to DONE.
REQ-013 RUN: SHALL assert o_rd_valid every cycle for k=0..7 with stage s; after k=7, SHALL go to DRAIN.
REQ-014 Read addresses for butterfly k in stage s SHALL be computed as follows: span=2^s, pos=k mod span, grp=k>>s, a=grp*2*span+pos, b=a+span, and tw=pos<<(3-s), all truncated to the port widths.
REQ-015 o_wr_en, o_wr_addr_a and o_wr_addr_b SHALL equal o_rd_valid, o_rd_addr_a and o_rd_addr_b delayed by exactly BFLY_LAT cycles.
REQ-016 DRAIN SHALL last exactly BFLY_LAT cycles, so the last write of a stage occurs in the final DRAIN cycle; on exit, o_bank_sel SHALL toggle.
REQ-017 On DRAIN exit, SHALL go to RUN with stage+1 and k=0 if stage+1<n, else to DONE.
REQ-018 Stage period SHALL be 8+BFLY_LAT cycles, and the next stage's first read SHALL follow the previous stage's last write with no gap.
REQ-019 DONE SHALL assert o_done for one cycle, then go to IDLE; o_bank_sel SHALL hold the result bank (n mod 2) until the next start.
REQ-020 o_busy SHALL be 1 exactly in RUN and DRAIN.
REQ-021 o_stage and o_tw_idx SHALL be 0 whenever o_rd_valid=0.
REQ-022 i_start SHALL be ignored in RUN, DRAIN and DONE.
REQ-023 i_abort=1 in RUN or DRAIN SHALL force IDLE on the next cycle, clear the write delay line so that no further o_wr_en occurs, and suppress o_done; o_bank_sel SHALL hold its value.
REQ-024 Abort SHALL take priority over a simultaneous stage or transform completion.
REQ-025 i_abort SHALL be ignored in IDLE and DONE; with i_start and i_abort both high in IDLE, start SHALL be accepted.
REQ-026 i_n_stages values 5..7 SHALL be treated as 4; a value of 0 SHALL give o_done one cycle after start with no reads or writes.

Reset
REQ-027 i_rst SHALL asynchronously force state IDLE, stage=0, k=0, and clear the delay line.
REQ-028 During reset, all outputs (o_busy, o_done, o_rd_valid, o_wr_en, all addresses, o_tw_idx, o_stage, o_bank_sel) SHALL be 0.
REQ-029 Reset asserted mid-transform SHALL drop o_busy and o_wr_en immediately, with no o_done afterwards.

Structure
REQ-030 Package fft_pkg SHALL hold N_POINTS=16, LOG2N=4, N_BFLY=8, MAX_STAGES=4 and the FSM state enum.
REQ-031 Address and twiddle generation (REQ-014) SHALL be a combinational sub-module fft_bfly_addr_gen (inputs stage and k; outputs a, b and tw).
REQ-032 The BFLY_LAT delay line SHALL be inline shift registers of valid and addresses, with asynchronous clear.

Verification
REQ-033 Bench SHALL cover: BFLY_LAT=3, i_n_stages=4, start at cycle 0 -> reads in cycles 1-8, 12-19, 23-30 and 34-41; o_done at cycle 45; o_bank_sel=0 at end; 32 writes total.
REQ-034 Bench SHALL cover: stage 0, k=5 -> a=10, b=11, tw=0; stage 2, k=5 -> a=9, b=13, tw=2; stage 3, k=5 -> a=5, b=13, tw=5.
REQ-035 Bench SHALL cover: i_n_stages=1 -> 8 reads, o_wr_en cycles 4-11, o_done at cycle 12, o_bank_sel=1; i_n_stages=6 behaves as 4.
REQ-036 Bench SHALL cover: i_n_stages=0 -> o_done at cycle 1, with o_rd_valid and o_wr_en never asserted.
REQ-037 Bench SHALL cover: i_abort in cycle 10 (DRAIN, stage 0) -> IDLE at cycle 11, no o_wr_en from cycle 11 on, no o_done, and i_start pulses during busy ignored.
REQ-038 Bench SHALL cover: i_rst asserted between clock edges in cycle 20 -> outputs 0 immediately; a subsequent start runs a full, correct transform.
